// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the multi-channel SPI DAC driver.
package spi_dac_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap, StFin} state_e;

  localparam int unsigned MODE_PER_CH = 0;
  localparam int unsigned MODE_DAISY  = 1;

  // Half SCLK period in clk cycles, rounded up so SCLK never exceeds f_sclk.
  function automatic int unsigned half_cnt(input int unsigned f_clk, input int unsigned f_sclk);
    int unsigned h;
    h = (f_clk + 2 * f_sclk - 1) / (2 * f_sclk);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: HALF cycles high then HALF cycles low while enabled, idle high.
// rise/fall flag the cycle before SCLK changes level.
module spi_sclk_gen #(
  parameter int unsigned HALF = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    wrap = en && (cnt_q == LAST);
    rise = wrap && !sclk_q;
    fall = wrap && sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      sclk_d = sclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_dac_mc.sv
// Multi-channel SPI DAC driver: one SYNC_n frame per enabled channel, or one
// daisy-chained frame of all channels, launched by a sample strobe.
module spi_dac_mc
  import spi_dac_pkg::*;
#(
  parameter int unsigned CH      = 2,
  parameter int unsigned BITS    = 24,
  parameter int unsigned fCLK    = 50_000_000,
  parameter int unsigned fSCLK   = 10_000_000,
  parameter int unsigned MODE    = MODE_PER_CH,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CH*BITS-1:0] in,
  input  logic [CH-1:0]      ch_en,
  input  logic               go,
  input  logic               ovr_clr,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               SS_n,
  output logic               SCLK,
  output logic               SDO
);

  localparam int unsigned HALF = half_cnt(fCLK, fSCLK);
  localparam int unsigned TOT  = CH * BITS;
  localparam int unsigned BCW  = $clog2(TOT + 1);
  localparam int unsigned CIW  = $clog2(CH) + 1;
  localparam int unsigned GCW  = $clog2(GAP_CYC + 1);

  state_e           state_q, state_d;
  logic [TOT-1:0]   in_q, in_d;
  logic [CH-1:0]    en_q, en_d;
  logic [CIW-1:0]   ch_idx_q, ch_idx_d;
  logic [TOT-1:0]   sreg_q, sreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic             ss_q, ss_d;
  logic             sdo_q, sdo_d;
  logic             ovr_q, ovr_d;
  logic             sclk_rise, sclk_fall;
  logic             found;
  logic [CIW-1:0]   nxt;

  spi_sclk_gen #(
    .HALF (HALF)
  ) u_sclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == StShift),
    .sclk    (SCLK),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Lowest enabled channel at or above the current index.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int k = int'(CH) - 1; k >= 0; k--) begin
      if (en_q[k] && (CIW'(k) >= ch_idx_q)) begin
        found = 1'b1;
        nxt   = CIW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      in_q      <= '0;
      en_q      <= '0;
      ch_idx_q  <= '0;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ss_q      <= 1'b1;
      sdo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      en_q      <= en_d;
      ch_idx_q  <= ch_idx_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ss_q      <= ss_d;
      sdo_q     <= sdo_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    en_d      = en_q;
    ch_idx_d  = ch_idx_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ss_d      = ss_q;
    sdo_d     = sdo_q;
    // A dropped go beats a simultaneous clear.
    ovr_d     = (go && busy) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

    unique case (state_q)
      StIdle: begin
        if (go) begin
          in_d     = in;
          en_d     = (MODE == MODE_DAISY) ? CH'(1) : ch_en;
          ch_idx_d = '0;
          state_d  = ((MODE == MODE_PER_CH) && (ch_en == '0)) ? StFin : StLoad;
        end
      end
      StLoad: begin
        sreg_d = '0;
        if (MODE == MODE_DAISY) begin
          for (int k = 0; k < int'(CH); k++) begin
            sreg_d[TOT-1-k*BITS -: BITS] = in_q[k*BITS +: BITS];
          end
          bit_cnt_d = BCW'(TOT);
        end else begin
          sreg_d[TOT-1 -: BITS] = in_q[nxt*BITS +: BITS];
          bit_cnt_d = BCW'(BITS);
        end
        ch_idx_d = nxt + CIW'(1);
        ss_d     = 1'b0;
        sdo_d    = sreg_d[TOT-1];
        state_d  = StShift;
      end
      StShift: begin
        if (sclk_fall) begin
          bit_cnt_d = bit_cnt_q - BCW'(1);
        end
        // Every bit has been sampled once the counter reaches zero.
        if (sclk_rise) begin
          if (bit_cnt_q == '0) begin
            ss_d      = 1'b1;
            sdo_d     = 1'b0;
            gap_cnt_d = '0;
            state_d   = StGap;
          end else begin
            sreg_d = sreg_q << 1;
            sdo_d  = sreg_d[TOT-1];
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GCW'(GAP_CYC - 1)) begin
          gap_cnt_d = '0;
          state_d   = found ? StLoad : StFin;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StFin);
    overrun = ovr_q;
    SS_n    = ss_q;
    SDO     = sdo_q;
  end

endmodule

// File: tb/tb_spi_dac_mc.sv
// Self-checking bench: per-channel, daisy-chain and faster-SCLK instances.
`timescale 1ns/1ps
module tb_spi_dac_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [47:0] din;
  logic [1:0]  ch_en;
  logic [2:0]  go_v;
  logic        ovr_clr;
  wire  [2:0]  busy_v, done_v, ovr_v, ss_v, sclk_v, sdo_v;

  always #10 clk = ~clk;

  spi_dac_mc u_dut (
    .clk(clk), .reset_n(reset_n), .in(din), .ch_en(ch_en), .go(go_v[0]), .ovr_clr(ovr_clr),
    .busy(busy_v[0]), .done(done_v[0]), .overrun(ovr_v[0]), .SS_n(ss_v[0]), .SCLK(sclk_v[0]),
    .SDO(sdo_v[0])
  );

  spi_dac_mc #(.MODE(1)) u_daisy (
    .clk(clk), .reset_n(reset_n), .in(din), .ch_en(ch_en), .go(go_v[1]), .ovr_clr(ovr_clr),
    .busy(busy_v[1]), .done(done_v[1]), .overrun(ovr_v[1]), .SS_n(ss_v[1]), .SCLK(sclk_v[1]),
    .SDO(sdo_v[1])
  );

  spi_dac_mc #(.fSCLK(12_500_000)) u_fast (
    .clk(clk), .reset_n(reset_n), .in(din), .ch_en(ch_en), .go(go_v[2]), .ovr_clr(ovr_clr),
    .busy(busy_v[2]), .done(done_v[2]), .overrun(ovr_v[2]), .SS_n(ss_v[2]), .SCLK(sclk_v[2]),
    .SDO(sdo_v[2])
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Results of the last transfer
  int          r_frames, r_done, r_done_cyc, r_min_gap, r_per, r_sdo_bad;
  int          r_bits[4];
  int          r_low[4];
  logic [63:0] r_data[4];
  logic        r_busy_after, r_timeout;

  // Strobe go on one instance and watch its pins until one cycle after done.
  // go2_at > 0 re-strobes go (with ovr_clr = clr2) and perturbs din at that cycle;
  // rst_bit > 0 asserts reset once that many bits of the first frame were sampled.
  task automatic xfer(input int inst, input int go2_at, input bit clr2, input int rst_bit);
    int          low, hi, nb;
    logic [63:0] sh;
    logic        pss, psc, s, c, d, dn, by;
    logic [47:0] din_save;
    time         tf0;
    r_frames = 0; r_done = 0; r_done_cyc = -1; r_min_gap = 1000; r_per = 0; r_sdo_bad = 0;
    r_busy_after = 1'b1; r_timeout = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_bits[i] = 0; r_low[i] = 0; r_data[i] = '0;
    end
    low = 0; hi = 0; nb = 0; sh = '0; pss = 1'b1; psc = 1'b1; tf0 = 0;
    din_save = din;
    @(negedge clk); go_v[inst] = 1'b1;
    @(negedge clk); go_v[inst] = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      s = ss_v[inst]; c = sclk_v[inst]; d = sdo_v[inst]; dn = done_v[inst]; by = busy_v[inst];
      if (cyc == 1) check("busy after go", by, 1);
      if (!s) begin
        if (pss) begin
          if (r_frames > 0 && hi < r_min_gap) r_min_gap = hi;
          low = 0; nb = 0; sh = '0;
        end
        low++;
        if (psc && !c) begin
          sh = {sh[62:0], d};
          nb++;
          if (r_frames == 0 && nb == 1) tf0 = $time;
          if (r_frames == 0 && nb == 2) r_per = int'($time - tf0);
        end
      end else begin
        if (!pss) begin
          if (r_frames < 4) begin
            r_data[r_frames] = sh; r_bits[r_frames] = nb; r_low[r_frames] = low;
          end
          r_frames++;
          hi = 0;
        end
        hi++;
        if (d) r_sdo_bad++;
      end
      if (dn) begin
        r_done++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if (r_done_cyc > 0 && cyc == r_done_cyc + 1) begin
        r_busy_after = by; r_timeout = 1'b0;
        break;
      end
      if (go2_at > 0 && cyc == go2_at) begin
        go_v[inst] = 1'b1; ovr_clr = clr2; din = ~din;
      end else if (go2_at > 0 && cyc == go2_at + 1) begin
        go_v[inst] = 1'b0; ovr_clr = 1'b0; din = din_save;
      end
      if (rst_bit > 0 && !s && nb == rst_bit) begin
        reset_n = 1'b0;
        #1;
        check("rst SS_n", ss_v[inst], 1);
        check("rst SCLK", sclk_v[inst], 1);
        check("rst busy", busy_v[inst], 0);
        check("rst SDO", sdo_v[inst], 0);
        @(negedge clk);
        reset_n = 1'b1; r_timeout = 1'b0;
        break;
      end
      pss = s; psc = c;
      @(negedge clk);
    end
    go_v[inst] = 1'b0; ovr_clr = 1'b0; din = din_save;
    check("transfer timeout", r_timeout, 0);
  endtask

  typedef struct {
    int          inst;
    logic [47:0] din;
    logic [1:0]  en;
    int          frames;
    logic [47:0] d0;
    logic [47:0] d1;
    int          bits;
    int          low;
    int          per;
    int          done_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 48'hA5A5A5_123456, 2'b11, 2, 48'h123456, 48'hA5A5A5, 24, 144, 120, 0};
    vecs[1] = '{0, 48'hA5A5A5_123456, 2'b10, 1, 48'hA5A5A5, 48'h0, 24, 144, 120, 0};
    vecs[2] = '{0, 48'hA5A5A5_123456, 2'b00, 0, 48'h0, 48'h0, 0, 0, 0, 1};
    vecs[3] = '{1, 48'hA5A5A5_123456, 2'b00, 1, 48'h123456_A5A5A5, 48'h0, 48, 288, 120, 0};
    vecs[4] = '{2, 48'hA5A5A5_123456, 2'b01, 1, 48'h123456, 48'h0, 24, 96, 80, 0};
    vecs[5] = '{0, 48'h000001_800000, 2'b11, 2, 48'h800000, 48'h000001, 24, 144, 120, 0};

    reset_n = 1'b0; din = '0; ch_en = '0; go_v = '0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset SS_n", ss_v[0], 1);
    check("reset SCLK", sclk_v[0], 1);
    check("reset SDO", sdo_v[0], 0);
    check("reset busy", busy_v[0], 0);
    check("reset done", done_v[0], 0);
    check("reset overrun", ovr_v[0], 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      din = vecs[i].din; ch_en = vecs[i].en;
      xfer(vecs[i].inst, 0, 1'b0, 0);
      check($sformatf("v%0d frames", i), r_frames, vecs[i].frames);
      check($sformatf("v%0d done count", i), r_done, 1);
      check($sformatf("v%0d busy after done", i), r_busy_after, 0);
      check($sformatf("v%0d SCLK period ns", i), r_per, vecs[i].per);
      check($sformatf("v%0d SDO high while SS_n high", i), r_sdo_bad, 0);
      if (vecs[i].frames >= 1) begin
        check($sformatf("v%0d frame0 data", i), r_data[0], vecs[i].d0);
        check($sformatf("v%0d frame0 bits", i), r_bits[0], vecs[i].bits);
        check($sformatf("v%0d frame0 SS_n low", i), r_low[0], vecs[i].low);
      end
      if (vecs[i].frames == 2) begin
        check($sformatf("v%0d frame1 data", i), r_data[1], vecs[i].d1);
        check($sformatf("v%0d frame1 bits", i), r_bits[1], vecs[i].bits);
        check($sformatf("v%0d frame1 SS_n low", i), r_low[1], vecs[i].low);
        check($sformatf("v%0d gap >= 4", i), r_min_gap >= 4, 1);
      end
      if (vecs[i].done_cyc != 0) begin
        check($sformatf("v%0d done latency", i), r_done_cyc, vecs[i].done_cyc);
      end
    end

    // Overlapping go with changed inputs: dropped, data unaffected, overrun set
    din = 48'hA5A5A5_123456; ch_en = 2'b11;
    xfer(0, 10, 1'b0, 0);
    check("ovr frames", r_frames, 2);
    check("ovr frame0 data", r_data[0], 48'h123456);
    check("ovr frame1 data", r_data[1], 48'hA5A5A5);
    check("ovr set", ovr_v[0], 1);

    // Clear together with an overlapping go: set wins
    xfer(0, 10, 1'b1, 0);
    check("ovr set beats clear", ovr_v[0], 1);

    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("ovr cleared", ovr_v[0], 0);

    // go during FIN: ignored, sets overrun
    ch_en = 2'b00;
    xfer(0, 1, 1'b0, 0);
    check("go in FIN ignored", r_busy_after, 0);
    check("go in FIN overrun", ovr_v[0], 1);

    // Reset in the middle of ch0, then a clean transfer
    ch_en = 2'b11;
    xfer(0, 0, 1'b0, 10);
    check("post-reset overrun", ovr_v[0], 0);
    xfer(0, 0, 1'b0, 0);
    check("post-reset frames", r_frames, 2);
    check("post-reset frame0", r_data[0], 48'h123456);
    check("post-reset frame1", r_data[1], 48'hA5A5A5);
    check("post-reset bits", r_bits[0], 24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
